if2id_fetch_queue: RTL and testbench
====================================

Name: if2id_fetch_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register.
- Sits between the fetch stage (IF) and the decode stage (ID) as a DEPTH-entry instruction/PC queue with a valid/ready push handshake.
- ID-side freeze holds the output stage; branch flush empties the whole queue.
- The output stage drives a NOP bubble with out_valid=0 whenever no fetched entry is available.

Parameters:
- INSTR_W, 32, instruction width in bits.
- PC_W, 32, PC width in bits.
- DEPTH, 4, number of queue entries; must be a power of 2 and at least 2.
- NOP_INSTR, 32'hE000_0000, bubble encoding (condition AL, data-processing, all fields zero); width INSTR_W.
- CNT_W, $clog2(DEPTH+1), occupancy counter width; derived, must not be overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_valid  in  1  IF presents a fetched instruction.
- in_ready  out  1  queue can accept a push; equals (count != DEPTH); depends on registered state only.
- pc_in  in  PC_W  PC associated with instruction_in.
- instruction_in  in  INSTR_W  fetched instruction.
- freeze  in  1  ID stall; holds the output stage and blocks pop.
- flush  in  1  branch taken; discards the queue contents and the output-stage entry.
- instruction  out  INSTR_W  instruction presented to ID (registered).
- pc_out  out  PC_W  PC presented to ID (registered).
- out_valid  out  1  1 = instruction/pc_out carry a real fetched entry; 0 = bubble.
- count  out  CNT_W  current queue occupancy, 0..DEPTH; excludes the output-stage entry.

Behaviour:
- Reset (rst=1 at an edge): count=0, read/write pointers=0, instruction=NOP_INSTR, pc_out=0, out_valid=0. Reset overrides flush, freeze and push. Reset asserted mid-operation discards all queued entries in that same edge.
- Storage: circular buffer with read/write pointers of $clog2(DEPTH) bits each. Pointers wrap naturally from DEPTH-1 to 0.
- push = in_valid & in_ready & ~flush. A push writes {pc_in, instruction_in} at the write pointer, increments the write pointer and increments count.
- A push attempted while in_ready=0 is ignored; the bench flags it as a protocol error.
- pop = ~freeze & ~flush & (count != 0). A pop loads the head entry into instruction/pc_out, sets out_valid=1, increments the read pointer and decrements count.
- With ~freeze & ~flush & count==0: instruction=NOP_INSTR, out_valid=0, pc_out holds its value.
- freeze=1 (without flush): instruction, pc_out and out_valid hold. No pop occurs; push is still permitted.
- flush=1 (rst=0): count=0, read pointer := write pointer, instruction=NOP_INSTR, out_valid=0, pc_out holds, and any same-cycle push is discarded.
  - Flush takes priority over freeze: a frozen stage is still flushed.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal at count==DEPTH only if in_ready was already 1; in_ready is 0 at full, so the push is blocked that cycle even if a pop occurs.
- No bypass: an entry pushed at edge k reaches the outputs at edge k+1 at the earliest. Minimum IF→ID latency is 2 edges from presentation.
- Ordering: entries leave in push order. The queue never duplicates or drops an entry except on flush or reset.
- count transitions per edge are exactly +1, -1 or 0, or go to 0 on flush or reset.

Test Plan:
- Reset then idle: rst=1 for 2 edges, in_valid=0 → instruction=32'hE0000000, pc_out=0, out_valid=0, count=0, in_ready=1.
- Streaming: push pc 0x00,0x04,0x08 with instruction_in 0xE3A01001,0xE3A02002,0xE0813002 on consecutive edges, freeze=0 → outputs show them in order starting 1 edge after each push, out_valid=1 each cycle, count never exceeds 1.
- Fill/full: freeze=1, push 5 entries with DEPTH=4 → count=4 and in_ready=0 after the 4th; 5th ignored. Release freeze → the 4 entries pop in order over 4 edges, then a NOP with out_valid=0.
- Flush during freeze: count=3, freeze=1, flush=1 with in_valid=1 on the same edge → count=0, instruction=0xE0000000, out_valid=0, pc_out unchanged, pushed entry absent from later output.
- Wrap-around: run 10 push/pop cycles at DEPTH=4 with pc incrementing by 4 from 0x100 → outputs 0x100..0x124 in order, no loss across pointer wrap.
- Reset mid-operation: count=2, out_valid=1, rst=1 for one edge with push and flush active → all outputs at reset values, count=0. The next push appears on the outputs 1 edge after it is accepted.

Source files
------------

// File: rtl/if2id_fetch_queue.sv
// IF->ID instruction/PC queue: DEPTH-entry circular buffer feeding a registered output stage.
// Push-to-output latency is 1 edge at best; in_ready drops at full, freeze holds the output and blocks pop.
module if2id_fetch_queue #(
  parameter int unsigned        INSTR_W   = 32,
  parameter int unsigned        PC_W      = 32,
  parameter int unsigned        DEPTH     = 4,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'hE000_0000,
  parameter int unsigned        CNT_W     = $clog2(DEPTH+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instruction_in,
  input  logic               freeze,
  input  logic               flush,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    pc_out,
  output logic               out_valid,
  output logic [CNT_W-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push;
  logic               pop;

  always_comb begin
    in_ready = (count != CNT_W'(DEPTH));
    push     = in_valid & in_ready & ~flush;
    pop      = ~freeze & ~flush & (count != '0);
  end

  // Storage has no reset; validity is tracked entirely by count and the pointers.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      instr_mem[wr_ptr] <= instruction_in;
      pc_mem[wr_ptr]    <= pc_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      instruction <= NOP_INSTR;
      pc_out      <= '0;
      out_valid   <= 1'b0;
    end else if (flush) begin
      // Dropping everything is just catching the read pointer up; pc_out keeps its last value.
      count       <= '0;
      rd_ptr      <= wr_ptr;
      instruction <= NOP_INSTR;
      out_valid   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr      <= rd_ptr + PTR_W'(1);
        instruction <= instr_mem[rd_ptr];
        pc_out      <= pc_mem[rd_ptr];
        out_valid   <= 1'b1;
      end else if (!freeze) begin
        instruction <= NOP_INSTR;
        out_valid   <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if2id_fetch_queue.sv
// Directed test-plan steps followed by a randomized phase, all checked against a queue-based model.
module tb_if2id_fetch_queue;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned DEPTH   = 4;
  localparam logic [INSTR_W-1:0] NOP = 32'hE000_0000;
  localparam int unsigned CNT_W   = $clog2(DEPTH+1);

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    pc_in;
  logic [INSTR_W-1:0] instruction_in;
  logic               freeze;
  logic               flush;
  logic [INSTR_W-1:0] instruction;
  logic [PC_W-1:0]    pc_out;
  logic               out_valid;
  logic [CNT_W-1:0]   count;

  if2id_fetch_queue #(
    .INSTR_W(INSTR_W), .PC_W(PC_W), .DEPTH(DEPTH), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .instruction_in(instruction_in), .freeze(freeze), .flush(flush),
    .instruction(instruction), .pc_out(pc_out), .out_valid(out_valid), .count(count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a plain FIFO of {pc, instr} plus the value ID should be seeing.
  logic [PC_W+INSTR_W-1:0] mq [$];
  logic [INSTR_W-1:0] m_instr;
  logic [PC_W-1:0]    m_pc;
  logic               m_valid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic v, input logic fr, input logic fl,
                            input logic [PC_W-1:0] p, input logic [INSTR_W-1:0] i);
    logic [PC_W+INSTR_W-1:0] head;
    bit can_push;
    if (r) begin
      mq.delete();
      m_instr = NOP; m_pc = '0; m_valid = 1'b0;
    end else if (fl) begin
      mq.delete();
      m_instr = NOP; m_valid = 1'b0;
    end else begin
      can_push = v && (mq.size() < DEPTH);
      if (!fr) begin
        if (mq.size() > 0) begin
          head = mq.pop_front();
          m_pc = head[PC_W+INSTR_W-1:INSTR_W];
          m_instr = head[INSTR_W-1:0];
          m_valid = 1'b1;
        end else begin
          m_instr = NOP; m_valid = 1'b0;
        end
      end
      if (can_push) mq.push_back({p, i});
    end
  endtask

  task automatic step(input logic r, input logic v, input logic fr, input logic fl,
                      input logic [PC_W-1:0] p, input logic [INSTR_W-1:0] i);
    @(negedge clk);
    rst = r; in_valid = v; freeze = fr; flush = fl; pc_in = p; instruction_in = i;
    #1;
    chk("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
    model_edge(r, v, fr, fl, p, i);
    @(posedge clk);
    #1;
    chk("instruction", 64'(instruction), 64'(m_instr));
    chk("pc_out", 64'(pc_out), 64'(m_pc));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("count", 64'(count), 64'(mq.size()));
  endtask

  logic [PC_W-1:0] saved_pc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; freeze = 1'b0; flush = 1'b0; pc_in = '0; instruction_in = '0;
    m_instr = NOP; m_pc = '0; m_valid = 1'b0;
    repeat (2) @(posedge clk);

    // Reset then idle
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("reset_instr", 64'(instruction), 64'h0000_0000_E000_0000);
    chk("reset_ready", 64'(in_ready), 64'd1);
    step(0, 0, 0, 0, 0, 0);

    // Streaming
    step(0, 1, 0, 0, 32'h00, 32'hE3A01001);
    step(0, 1, 0, 0, 32'h04, 32'hE3A02002);
    chk("stream_first", 64'(pc_out), 64'h00);
    step(0, 1, 0, 0, 32'h08, 32'hE0813002);
    step(0, 0, 0, 0, 0, 0);
    chk("stream_last", 64'(instruction), 64'hE081_3002);
    step(0, 0, 0, 0, 0, 0);

    // Fill to full under freeze; 5th push must be ignored
    for (int k = 0; k < 5; k++) step(0, 1, 1, 0, 32'h200 + 32'(4*k), 32'hE3A0_0000 + 32'(k));
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(in_ready), 64'd0);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0, 0);
    chk("drain_bubble", 64'(out_valid), 64'd0);

    // Flush during freeze with a same-cycle push
    for (int k = 0; k < 3; k++) step(0, 1, 1, 0, 32'h300 + 32'(4*k), 32'hE1A0_0000 + 32'(k));
    saved_pc = pc_out;
    step(0, 1, 1, 1, 32'h3FC, 32'hDEAD_BEEF);
    chk("flush_pc_hold", 64'(pc_out), 64'(saved_pc));
    chk("flush_count", 64'(count), 64'd0);
    for (int k = 0; k < 2; k++) step(0, 0, 0, 0, 0, 0);

    // Wrap-around: continuous push/pop across pointer wrap
    for (int k = 0; k < 10; k++) step(0, 1, 0, 0, 32'h100 + 32'(4*k), 32'hE280_0000 + 32'(k));
    chk("wrap_pc", 64'(pc_out), 64'h120);
    step(0, 0, 0, 0, 0, 0);
    chk("wrap_last", 64'(pc_out), 64'h124);

    // Reset mid-operation with push and flush active
    step(0, 1, 0, 0, 32'h400, 32'hE3A0_1111);
    step(0, 1, 0, 0, 32'h404, 32'hE3A0_2222);
    step(0, 1, 1, 0, 32'h408, 32'hE3A0_3333);
    chk("pre_reset_count", 64'(count), 64'd2);
    step(1, 1, 0, 1, 32'h40C, 32'hE3A0_4444);
    chk("midrst_pc", 64'(pc_out), 64'd0);
    step(0, 1, 0, 0, 32'h500, 32'hE3A0_5555);
    step(0, 0, 0, 0, 0, 0);
    chk("post_reset_push", 64'(pc_out), 64'h500);

    // Randomized phase
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 11) == 0),
           $urandom, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
